// File: rtl/cpu_step_pkg.sv
// Shared mode encodings, FSM state type and enable-source selection
// for the CPU step controller.
package cpu_step_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SLOW   = 2'b01;
    localparam logic [1:0] MODE_FAST   = 2'b10;
    localparam logic [1:0] MODE_EX     = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        SWITCH = 1'b1
    } step_state_e;

    // Selects the raw step request for the mode currently in effect.
    function automatic logic pick_src(
        input logic [1:0] mode,
        input logic       btn_rise,
        input logic       slow_tick,
        input logic       fast_tick
    );
        logic src;
        src = 1'b0;
        unique case (mode)
            MODE_MANUAL: src = btn_rise;
            MODE_SLOW:   src = slow_tick;
            MODE_FAST:   src = fast_tick;
            MODE_EX:     src = 1'b1;
            default:     src = 1'b0;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser, stability-count debouncer and
// single-cycle rising-edge pulse.
module btn_debounce
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic ui_clk_from_ddr,
    input  logic rst,
    input  logic manual_clk,
    output logic btn_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s1;
    logic             btn_s;
    logic             btn_db;
    logic             btn_db_q;
    logic [CNT_W-1:0] db_cnt;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge ui_clk_from_ddr) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            btn_s1 <= manual_clk;
            btn_s  <= btn_s1;
        end
    end

    // Accept a new level only after it has held for the full window.
    always_ff @(posedge ui_clk_from_ddr) begin
        if (rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign btn_rise = btn_db & ~btn_db_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU single-cycle step enable generator: manual, slow, fast, free-run.
// Optional step counter output enabled by defining STEP_COUNT_EN.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int SLOW_LOG2       = 22,
    parameter int FAST_LOG2       = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic        ui_clk_from_ddr,
    input  logic        rst,
    input  logic [7:6]  SW,
    input  logic        manual_clk,
    input  logic        halt,
`ifdef STEP_COUNT_EN
    output logic [31:0] step_count,
`endif
    output logic        cpu_en,
    output logic [1:0]  mode_cur,
    output logic        switching
);

    logic [1:0]           sw_s1;
    logic [1:0]           sw_s;
    logic [SLOW_LOG2-1:0] div_cnt;
    logic                 btn_rise;
    logic                 slow_tick;
    logic                 fast_tick;
    logic                 src;
    logic                 mode_hit;
    step_state_e          state;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .ui_clk_from_ddr(ui_clk_from_ddr),
        .rst            (rst),
        .manual_clk     (manual_clk),
        .btn_rise       (btn_rise)
    );

    // Two-flop synchroniser for the mode switches.
    always_ff @(posedge ui_clk_from_ddr) begin
        if (rst) begin
            sw_s1 <= 2'b00;
            sw_s  <= 2'b00;
        end else begin
            sw_s1 <= SW;
            sw_s  <= sw_s1;
        end
    end

    // Free-running divider, restarted on every mode change.
    always_ff @(posedge ui_clk_from_ddr) begin
        if (rst || state == SWITCH) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign slow_tick = &div_cnt;
    assign fast_tick = &div_cnt[FAST_LOG2-1:0];
    assign mode_hit  = (sw_s == mode_cur);

    // Step request for the mode in effect.
    always_comb begin
        src = 1'b0;
        src = pick_src(mode_cur, btn_rise, slow_tick, fast_tick);
    end

    // Mode FSM with one blackout cycle; owns all registered outputs.
    always_ff @(posedge ui_clk_from_ddr) begin
        if (rst) begin
            state     <= RUN;
            mode_cur  <= MODE_MANUAL;
            switching <= 1'b0;
            cpu_en    <= 1'b0;
        end else begin
            cpu_en <= src & ~halt & (state == RUN) & mode_hit;
            unique case (state)
                RUN: begin
                    if (!mode_hit) begin
                        state     <= SWITCH;
                        switching <= 1'b1;
                    end
                end
                SWITCH: begin
                    mode_cur  <= sw_s;
                    state     <= RUN;
                    switching <= 1'b0;
                end
                default: begin
                    state     <= RUN;
                    switching <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_COUNT_EN
    // Counts every issued step; wraps naturally at 2^32.
    always_ff @(posedge ui_clk_from_ddr) begin
        if (rst) begin
            step_count <= '0;
        end else if (cpu_en) begin
            step_count <= step_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: table-driven reset/free-run/fast
// vectors followed by hand-written slow, manual and reset sequences.
module tb_cpu_step_ctrl;

    logic        clk;
    logic        rst;
    logic [7:6]  SW;
    logic        manual_clk;
    logic        halt;
    logic        cpu_en;
    logic [1:0]  mode_cur;
    logic        switching;
`ifdef STEP_COUNT_EN
    logic [31:0] step_count;
`endif

    int checks = 0;
    int errors = 0;

    cpu_step_ctrl #(
        .SLOW_LOG2      (4),
        .FAST_LOG2      (2),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .ui_clk_from_ddr(clk),
        .rst            (rst),
        .SW             (SW),
        .manual_clk     (manual_clk),
        .halt           (halt),
`ifdef STEP_COUNT_EN
        .step_count     (step_count),
`endif
        .cpu_en         (cpu_en),
        .mode_cur       (mode_cur),
        .switching      (switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [1:0] sw;
        logic       halt;
        logic       exp_en;
        logic       exp_swi;
        logic [1:0] exp_mode;
    } vec_t;

    localparam int NV = 31;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for the blackout cycle; returns 1 if seen.
    task automatic wait_switch(input string name, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (switching === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: switching not seen within 10 cycles", name);
        end
    endtask

    initial begin
        vec_t vecs [NV];
        logic seen;
        int   pulses;

        vecs = '{
            '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00},
            '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00},
            '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00},
            '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00},
            '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00},
            '{1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00},
            '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11},
            '{1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11},
            '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b11},
            '{1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11},
            '{1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11},
            '{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b11},
            '{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b11},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2'b11},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10},
            '{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10}
        };

        manual_clk = 1'b0;
        halt       = 1'b0;
        rst        = 1'b1;
        SW         = 2'b11;

        // Reset, free-run, halt, switch 11 -> 10, fast pulses
        for (int i = 0; i < NV; i++) begin
            rst  = vecs[i].rst;
            SW   = vecs[i].sw;
            halt = vecs[i].halt;
            tick();
            check($sformatf("vec%0d cpu_en", i), cpu_en, vecs[i].exp_en);
            check($sformatf("vec%0d switching", i), switching, vecs[i].exp_swi);
            check($sformatf("vec%0d mode_cur", i), mode_cur, vecs[i].exp_mode);
        end
        halt = 1'b0;

        // Fast mode steady state: 25 pulses in 100 cycles
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cpu_en === 1'b1) pulses++;
        end
        check("fast pulses/100", pulses, 25);

        // Reset mid-run drops cpu_en and forces manual mode
        rst = 1'b1;
        SW  = 2'b01;
        tick();
        check("midrst cpu_en", cpu_en, 1'b0);
        check("midrst mode_cur", mode_cur, 2'b00);
        check("midrst switching", switching, 1'b0);
        tick();
        rst = 1'b0;

        // Slow mode: period 16, halted pulse lost, next 16 later
        wait_switch("slow switch", seen);
        tick();
        check("slow mode_cur", mode_cur, 2'b01);
        check("slow blackout end", switching, 1'b0);
        for (int k = 1; k <= 48; k++) begin
            halt = (k == 32);
            tick();
            check($sformatf("slow off%0d", k), cpu_en,
                  (k == 16 || k == 48) ? 1'b1 : 1'b0);
        end
        halt = 1'b0;

        // Manual mode: bouncy press gives one pulse, release none
        SW = 2'b00;
        wait_switch("manual switch", seen);
        tick();
        check("manual mode_cur", mode_cur, 2'b00);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (i < 10 && (i % 2) == 0) manual_clk = ~manual_clk;
            tick();
            if (cpu_en === 1'b1) pulses++;
        end
        check("press pulses", pulses, 1);
        check("press level", manual_clk, 1'b1);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (i < 10 && (i % 2) == 0) manual_clk = ~manual_clk;
            tick();
            if (cpu_en === 1'b1) pulses++;
        end
        check("release pulses", pulses, 0);

        // Reset discards an in-flight debounce count
        manual_clk = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < 25; r++) begin
            tick();
            check($sformatf("rstdb row%0d", r), cpu_en,
                  (r == 18) ? 1'b1 : 1'b0);
        end
        manual_clk = 1'b0;

`ifdef STEP_COUNT_EN
        // Step counter: 50 steps free-running, then 40 with 10 halted
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            SW  = 2'b11;
            tick();
            check("cnt reset", step_count, 0);
            tick();
            rst = 1'b0;
            wait_switch("cnt switch", seen);
            for (int m = 1; m <= 52; m++) begin
                halt = (pass == 1) && (m >= 10) && (m <= 19);
                tick();
            end
            halt = 1'b0;
            check($sformatf("step_count pass%0d", pass), step_count,
                  (pass == 0) ? 32'd50 : 32'd40);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
